mont_domain_encoder: RTL

- Converts standard-domain NTT coefficients into Montgomery form: out = (in * 2^R_BITS) mod Q, canonical range [0, Q).
- Input side of the Montgomery datapath. The existing 32-bit Montgomery reduction pipeline maps a*R back to a. Together the two blocks form the enter/leave pair around the NTT butterfly multipliers.
- Iterative, area-minimal design: one adder/subtractor, fixed latency. Uses the same load/en/valid handshake style as the reduction unit.

---
 rtl/mont_domain_encoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/mont_domain_encoder.sv
// Montgomery-domain encoder: out = (in * 2^R_BITS) mod Q, computed iteratively
// with a single shared subtractor (3 pre-reduction steps, then R_BITS doublings).
module mont_domain_encoder #(
  parameter int Q      = 12289,
  parameter int R_BITS = 18,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic          valid,
  output logic          busy
);

  localparam int XW = 17;
  localparam int CW = $clog2(R_BITS);

  localparam logic [XW:0] Q1 = (XW+1)'(Q);
  localparam logic [XW:0] Q2 = (XW+1)'(2 * Q);
  localparam logic [XW:0] Q4 = (XW+1)'(4 * Q);

  typedef enum logic [1:0] {IDLE, PRE, SHIFT} state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x;
  logic [CW-1:0] cnt;
  logic [XW:0]   op_a, op_b, diff;
  logic [XW-1:0] x_step;
  logic          ge;
  logic          last_pre, last_shift;

  assign last_pre   = (cnt == CW'(2));
  assign last_shift = (state == SHIFT) && (cnt == CW'(R_BITS - 1));

  // Shared subtractor: PRE subtracts 4Q/2Q/Q from x, SHIFT subtracts Q from 2x.
  // The extra top bit of diff is the borrow, so ge is an unsigned compare.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      PRE: begin
        op_a = {1'b0, x};
        op_b = (cnt == CW'(0)) ? Q4 : (cnt == CW'(1)) ? Q2 : Q1;
      end
      SHIFT: begin
        op_a = {3'b000, x[13:0], 1'b0};
        op_b = Q1;
      end
      default: ;
    endcase
    diff   = op_a - op_b;
    ge     = ~diff[XW];
    x_step = ge ? diff[XW-1:0] : op_a[XW-1:0];
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   state <= IDLE;
    else if (en) state <= state_nx;
  end

  // Next-state logic.
  // NOTE: state_nx gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load)       state_nx = PRE;
      PRE:     if (last_pre)   state_nx = SHIFT;
      SHIFT:   if (last_shift) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Datapath registers; valid is set only by a completing SHIFT edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x     <= '0;
      cnt   <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      valid <= last_shift;
      case (state)
        IDLE: begin
          if (load) begin
            x   <= {1'b0, in};
            cnt <= '0;
          end
        end
        PRE: begin
          x   <= x_step;
          cnt <= last_pre ? '0 : cnt + CW'(1);
        end
        SHIFT: begin
          x   <= x_step;
          cnt <= last_shift ? '0 : cnt + CW'(1);
          if (last_shift) out <= x_step[DW-1:0];
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule
